cordic_peak_detect: RTL and testbench

- Downstream consumer of the CORDIC magnitude/phase stage in the FFT chain.
- Accepts one (amplitude, theta) pair per FFT bin and tracks frames of NFFT bins.
- Reports the bin index, amplitude and phase of the largest-magnitude bin once per frame.
- Flags malformed (short) frames.

---
 rtl/cordic_peak_detect.sv | 121 ++++++++++++
 tb/tb_cordic_peak_detect.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_peak_detect.sv
// Per-frame peak search over CORDIC (amplitude, theta) bins: reports the strongest bin once per NFFT-bin frame.
// Optional PEAK_THRESH_EN adds a `thresh` input; frames whose peak falls below it report no peak.
module cordic_peak_detect #(
    parameter int WIDTH     = 16,
    parameter int NFFT      = 1024,
    parameter int IDX_W     = 10,
    parameter int HALF_SPEC = 1,
    parameter int SKIP_DC   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic [WIDTH-1:0] in_amp,
    input  logic [WIDTH-1:0] in_theta,
`ifdef PEAK_THRESH_EN
    input  logic [WIDTH-1:0] thresh,
`endif
    output logic             peak_valid,
    output logic [IDX_W-1:0] peak_idx,
    output logic [WIDTH-1:0] peak_amp,
    output logic [WIDTH-1:0] peak_theta,
    output logic             frame_err,
    output logic [15:0]      frame_cnt
);

    localparam logic [IDX_W-1:0] HALF_IDX = IDX_W'(NFFT / 2);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NFFT - 1);

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t           state;
    logic [IDX_W-1:0] bin_cnt;
    logic [WIDTH-1:0] best_amp;
    logic [IDX_W-1:0] best_idx;
    logic [WIDTH-1:0] best_theta;

    logic             eligible;
    logic             take;
    logic [WIDTH-1:0] nxt_amp;
    logic [IDX_W-1:0] nxt_idx;
    logic [WIDTH-1:0] nxt_theta;
    logic [WIDTH-1:0] dc_amp;
    logic [WIDTH-1:0] dc_theta;
    logic             below_thresh;

    // Running best including the current sample, so the last bin's comparison lands in the report.
    always_comb begin
        eligible  = ((HALF_SPEC == 0) || (bin_cnt < HALF_IDX)) &&
                    ((SKIP_DC == 0) || (bin_cnt != '0));
        take      = eligible && (in_amp > best_amp);
        nxt_amp   = take ? in_amp   : best_amp;
        nxt_idx   = take ? bin_cnt  : best_idx;
        nxt_theta = take ? in_theta : best_theta;
        dc_amp    = (SKIP_DC != 0) ? '0 : in_amp;
        dc_theta  = (SKIP_DC != 0) ? '0 : in_theta;
`ifdef PEAK_THRESH_EN
        below_thresh = (nxt_amp < thresh);
`else
        below_thresh = 1'b0;
`endif
    end

    // NOTE: every register here, outputs included, is cleared by the async reset and updated with <= only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            bin_cnt    <= '0;
            best_amp   <= '0;
            best_idx   <= '0;
            best_theta <= '0;
            peak_valid <= 1'b0;
            peak_idx   <= '0;
            peak_amp   <= '0;
            peak_theta <= '0;
            frame_err  <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            peak_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid && in_sof) begin
                        state      <= ACCUM;
                        bin_cnt    <= IDX_W'(1);
                        best_amp   <= dc_amp;
                        best_idx   <= '0;
                        best_theta <= dc_theta;
                    end
                end
                ACCUM: begin
                    if (in_valid && in_sof) begin
                        // Short frame: flag it and treat this sample as bin 0 of a fresh frame.
                        frame_err  <= 1'b1;
                        bin_cnt    <= IDX_W'(1);
                        best_amp   <= dc_amp;
                        best_idx   <= '0;
                        best_theta <= dc_theta;
                    end else if (in_valid) begin
                        best_amp   <= nxt_amp;
                        best_idx   <= nxt_idx;
                        best_theta <= nxt_theta;
                        bin_cnt    <= bin_cnt + 1'b1;
                        if (bin_cnt == LAST_IDX) begin
                            state     <= IDLE;
                            frame_cnt <= frame_cnt + 16'd1;
                            if (!below_thresh) begin
                                peak_valid <= 1'b1;
                                peak_idx   <= nxt_idx;
                                peak_amp   <= nxt_amp;
                                peak_theta <= nxt_theta;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_peak_detect.sv
// Directed bench for cordic_peak_detect: dut_a uses HALF_SPEC=1/SKIP_DC=1, dut_b uses 0/0, same stimulus.
module tb_cordic_peak_detect;

    localparam int W  = 16;
    localparam int N  = 16;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_sof;
    logic [W-1:0]  in_amp;
    logic [W-1:0]  in_theta;
`ifdef PEAK_THRESH_EN
    logic [W-1:0]  thresh;
`endif

    logic          pv_a, fe_a, pv_b, fe_b;
    logic [IW-1:0] idx_a, idx_b;
    logic [W-1:0]  amp_a, amp_b, th_a, th_b;
    logic [15:0]   fc_a, fc_b;

    cordic_peak_detect #(.WIDTH(W), .NFFT(N), .IDX_W(IW), .HALF_SPEC(1), .SKIP_DC(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof),
        .in_amp(in_amp), .in_theta(in_theta),
`ifdef PEAK_THRESH_EN
        .thresh(thresh),
`endif
        .peak_valid(pv_a), .peak_idx(idx_a), .peak_amp(amp_a), .peak_theta(th_a),
        .frame_err(fe_a), .frame_cnt(fc_a)
    );

    cordic_peak_detect #(.WIDTH(W), .NFFT(N), .IDX_W(IW), .HALF_SPEC(0), .SKIP_DC(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof),
        .in_amp(in_amp), .in_theta(in_theta),
`ifdef PEAK_THRESH_EN
        .thresh(thresh),
`endif
        .peak_valid(pv_b), .peak_idx(idx_b), .peak_amp(amp_b), .peak_theta(th_b),
        .frame_err(fe_b), .frame_cnt(fc_b)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Pulse counters, sampled on the falling edge.
    int n_pv_a = 0;
    int n_pv_b = 0;
    int n_fe_a = 0;
    always @(negedge clk) begin
        n_pv_a <= n_pv_a + int'(pv_a);
        n_pv_b <= n_pv_b + int'(pv_b);
        n_fe_a <= n_fe_a + int'(fe_a);
    end

    typedef struct {
        int           ia;   logic [W-1:0] aa; logic [W-1:0] ta;
        int           ib;   logic [W-1:0] ab;
        int           ic;   logic [W-1:0] ac;
        logic [W-1:0] bg;
        int           e1_idx; logic [W-1:0] e1_amp; logic [W-1:0] e1_th;
        int           e2_idx; logic [W-1:0] e2_amp; logic [W-1:0] e2_th;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic sof, input logic [W-1:0] amp, input logic [W-1:0] theta);
        @(negedge clk);
        in_valid = 1'b1;
        in_sof   = sof;
        in_amp   = amp;
        in_theta = theta;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_sof   = 1'b0;
        end
    endtask

    // Called one negedge after the last bin was driven: the pulse must be up now and gone next cycle.
    task automatic expect_peak(input string nm, input int i1, input logic [W-1:0] a1,
                               input logic [W-1:0] t1, input int i2, input logic [W-1:0] a2,
                               input logic [W-1:0] t2);
        check({nm, "_pv_a"},  32'(pv_a),  1);
        check({nm, "_idx_a"}, 32'(idx_a), i1);
        check({nm, "_amp_a"}, 32'(amp_a), 32'(a1));
        check({nm, "_th_a"},  32'(th_a),  32'(t1));
        check({nm, "_pv_b"},  32'(pv_b),  1);
        check({nm, "_idx_b"}, 32'(idx_b), i2);
        check({nm, "_amp_b"}, 32'(amp_b), 32'(a2));
        check({nm, "_th_b"},  32'(th_b),  32'(t2));
        idle(1);
        check({nm, "_pv_one_cycle"}, 32'(pv_a), 0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
    endtask

    function automatic logic [W-1:0] amp_of(input int i, input vec_t v);
        if (i == v.ia) return v.aa;
        if (i == v.ib) return v.ab;
        if (i == v.ic) return v.ac;
        return v.bg;
    endfunction

    function automatic logic [W-1:0] theta_of(input int i, input vec_t v);
        return (i == v.ia) ? v.ta : W'(100 + i);
    endfunction

    int exp_fc;
    int p0, pb0, f0;

    initial begin
        // ia aa ta | ib ab | ic ac | bg | dut_a idx amp th | dut_b idx amp th ; default theta is 100+bin
        vecs[0] = '{-1, 0, 0,         -1, 0,     -1, 0,   0,     0, 0,     0,          0,  0,     100};
        vecs[1] = '{3,  500, 16'hFB2E, -1, 0,     -1, 0,   10,    3, 500,   16'hFB2E,   3,  500,   16'hFB2E};
        vecs[2] = '{0,  9000, 100,     12, 800,   5,  300, 0,     5, 300,   105,        0,  9000,  100};
        vecs[3] = '{2,  700, 102,      6,  700,   -1, 0,   0,     2, 700,   102,        2,  700,   102};
        vecs[4] = '{15, 60000, 115,    -1, 0,     -1, 0,   1,     1, 1,     101,        15, 60000, 115};
        vecs[5] = '{7,  40000, 107,    8,  50000, -1, 0,   5,     7, 40000, 107,        8,  50000, 108};

        rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_amp = '0; in_theta = '0;
`ifdef PEAK_THRESH_EN
        thresh = '0;
`endif
        #12;
        check("rst_pv",  32'(pv_a),  0);
        check("rst_idx", 32'(idx_a), 0);
        check("rst_amp", 32'(amp_a), 0);
        check("rst_th",  32'(th_a),  0);
        check("rst_fe",  32'(fe_a),  0);
        check("rst_fc",  32'(fc_a),  0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        exp_fc = 0;
        foreach (vecs[k]) begin
            for (int i = 0; i < N; i++) drive(i == 0, amp_of(i, vecs[k]), theta_of(i, vecs[k]));
            idle(1);
            exp_fc++;
            expect_peak($sformatf("vec%0d", k), vecs[k].e1_idx, vecs[k].e1_amp, vecs[k].e1_th,
                        vecs[k].e2_idx, vecs[k].e2_amp, vecs[k].e2_th);
            check($sformatf("vec%0d_fc", k), 32'(fc_a), exp_fc);
        end

        // Short frame with gaps, in_sof again at bin 9, then the restarted frame completes.
        idle(2);
        p0 = n_pv_a; f0 = n_fe_a;
        for (int i = 0; i < 9; i++) begin
            drive(i == 0, (i == 3) ? W'(5000) : W'(20), W'(100 + i));
            idle(i % 3);
        end
        drive(1'b1, '0, W'(100));
        idle(1);
        check("short_fe_a", 32'(fe_a), 1);
        check("short_fe_b", 32'(fe_b), 1);
        check("short_no_pv", 32'(pv_a), 0);
        for (int i = 1; i < N; i++) begin
            drive(1'b0, (i == 4) ? W'(222) : W'(3), W'(100 + i));
            idle(i % 2);
        end
        if (N % 2 == 0) idle(0);
        check("short_gap_tail_pv", 32'(pv_a), 1);
        exp_fc++;
        expect_peak("restart", 4, 222, 104, 4, 222, 104);
        idle(3);
        check("short_pv_count", n_pv_a - p0, 1);
        check("short_fe_count", n_fe_a - f0, 1);
        check("short_fc", 32'(fc_a), exp_fc);

`ifdef PEAK_THRESH_EN
        thresh = W'(400);
        p0 = n_pv_a;
        for (int i = 0; i < N; i++) drive(i == 0, (i == 3) ? W'(350) : W'(0), W'(100 + i));
        idle(4);
        exp_fc++;
        check("thr_low_no_pv", n_pv_a - p0, 0);
        check("thr_low_fc",    32'(fc_a), exp_fc);
        check("thr_low_hold_idx", 32'(idx_a), 4);
        check("thr_low_hold_amp", 32'(amp_a), 222);
        for (int i = 0; i < N; i++) drive(i == 0, (i == 6) ? W'(450) : W'(0), W'(100 + i));
        idle(1);
        exp_fc++;
        expect_peak("thr_high", 6, 450, 106, 6, 450, 106);
        check("thr_high_fc", 32'(fc_a), exp_fc);
        thresh = '0;
`endif

        // Back-to-back frames from a fresh reset: sof directly follows the last bin.
        pulse_reset();
        p0 = n_pv_a; pb0 = n_pv_b;
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < N; i++)
                drive(i == 0, (f == 0 && i == 2) ? W'(1000) : (f == 1 && i == 5) ? W'(2000) : W'(7),
                      W'(100 + i));
        idle(1);
        expect_peak("b2b", 5, 2000, 105, 5, 2000, 105);
        idle(2);
        check("b2b_pv_count_a", n_pv_a - p0, 2);
        check("b2b_pv_count_b", n_pv_b - pb0, 2);
        check("b2b_fc", 32'(fc_a), 2);

        // Reset asserted at bin 7 of a frame.
        p0 = n_pv_a; f0 = n_fe_a;
        for (int i = 0; i < 7; i++) drive(i == 0, W'(50), W'(100 + i));
        drive(1'b0, W'(50), W'(107));
        rst_n = 1'b0;
        #1;
        check("midrst_idx", 32'(idx_a), 0);
        check("midrst_amp", 32'(amp_a), 0);
        check("midrst_th",  32'(th_a),  0);
        check("midrst_fc",  32'(fc_a),  0);
        idle(2);
        rst_n = 1'b1;
        idle(4);
        check("midrst_no_pv", n_pv_a - p0, 0);
        check("midrst_no_fe", n_fe_a - f0, 0);
        check("midrst_fc_after", 32'(fc_a), 0);

        // Samples without sof in IDLE are ignored; the next frame is clean.
        for (int i = 0; i < 5; i++) drive(1'b0, W'(9999), W'(7));
        for (int i = 0; i < N; i++) drive(i == 0, (i == 2) ? W'(77) : W'(0), W'(100 + i));
        idle(1);
        expect_peak("after_rst", 2, 77, 102, 2, 77, 102);
        check("after_rst_fc", 32'(fc_a), 1);

        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
